// File: rtl/buffer_dma_mst.sv
// buffer_dma_mst
// AXI4 write master that moves one tile of BEATS_g words from a streaming
// source into one of two double-buffered systolic-array input buffers.
// It picks a free buffer, issues a one-cycle grant, then performs a single
// INCR burst (AW, W, B) to that buffer's base address.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i                 request one tile (sampled in IDLE only)
//   busy_o, done_o, err_o   status; done_o/err_o are one-cycle pulses
//   buf_sel_o               buffer currently / last filled
//   src_valid_i/src_ready_o/src_data_i   source word stream
//   buf_available_i         per-buffer free status
//   buf_grant_o             one-hot single-cycle grant pulse
//   m_axi_aw*, m_axi_w*, m_axi_b*         AXI4 write channels
module buffer_dma_mst #(
   parameter int                  AXI_DW_g    = 64,
   parameter int                  AXI_AW_g    = 32,
   parameter int                  BEATS_g     = 16,
   parameter logic [AXI_AW_g-1:0] BUF0_BASE_g = 'h0000_0000,
   parameter logic [AXI_AW_g-1:0] BUF1_BASE_g = 'h0000_1000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic                  buf_sel_o,
   input  logic                  src_valid_i,
   output logic                  src_ready_o,
   input  logic [AXI_DW_g-1:0]   src_data_i,
   input  logic [1:0]            buf_available_i,
   output logic [1:0]            buf_grant_o,
   output logic                  m_axi_awvalid_o,
   input  logic                  m_axi_awready_i,
   output logic [AXI_AW_g-1:0]   m_axi_awaddr_o,
   output logic [7:0]            m_axi_awlen_o,
   output logic [2:0]            m_axi_awsize_o,
   output logic [1:0]            m_axi_awburst_o,
   output logic                  m_axi_wvalid_o,
   input  logic                  m_axi_wready_i,
   output logic [AXI_DW_g-1:0]   m_axi_wdata_o,
   output logic [AXI_DW_g/8-1:0] m_axi_wstrb_o,
   output logic                  m_axi_wlast_o,
   input  logic                  m_axi_bvalid_i,
   output logic                  m_axi_bready_o,
   input  logic [1:0]            m_axi_bresp_i
);

   localparam int            CW      = $clog2(BEATS_g) + 1;
   localparam logic [CW-1:0] BEATS_C = CW'(BEATS_g);
   localparam logic [CW-1:0] LAST_C  = CW'(BEATS_g - 1);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_SELECT, ST_GRANT, ST_ADDR, ST_DATA, ST_RESP
   } state_t;

   state_t                state_reg;
   logic                  last_buf_reg;
   logic                  buf_sel_reg;
   logic [1:0]            grant_reg;
   logic                  awvalid_reg;
   logic [AXI_AW_g-1:0]   awaddr_reg;
   logic                  wvalid_reg;
   logic [AXI_DW_g-1:0]   wdata_reg;
   logic [CW-1:0]         loaded_cnt_reg;
   logic [CW-1:0]         sent_cnt_reg;
   logic                  bready_reg;
   logic                  done_reg;
   logic                  err_reg;

   logic src_ready;
   logic src_load;
   logic w_hs;
   logic wlast;
   logic pick;

   // The single output register may take a new word when it is empty or is
   // being drained this cycle, which gives one beat per cycle when streaming.
   assign src_ready = (state_reg == ST_DATA) && (!wvalid_reg || m_axi_wready_i) &&
                      (loaded_cnt_reg < BEATS_C);
   assign src_load  = src_valid_i && src_ready;
   assign w_hs      = wvalid_reg && m_axi_wready_i;
   assign wlast     = wvalid_reg && (sent_cnt_reg == LAST_C);

   // Alternate when both buffers are free, otherwise take the free one.
   assign pick = (&buf_available_i) ? ~last_buf_reg : buf_available_i[1];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg      <= ST_IDLE;
         last_buf_reg   <= 1'b1;
         buf_sel_reg    <= 1'b0;
         grant_reg      <= 2'b00;
         awvalid_reg    <= 1'b0;
         awaddr_reg     <= '0;
         wvalid_reg     <= 1'b0;
         wdata_reg      <= '0;
         loaded_cnt_reg <= '0;
         sent_cnt_reg   <= '0;
         bready_reg     <= 1'b0;
         done_reg       <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
         grant_reg <= 2'b00;
         case (state_reg)
            ST_IDLE: begin
               if (start_i) state_reg <= ST_SELECT;
            end
            ST_SELECT: begin
               if (|buf_available_i) begin
                  buf_sel_reg  <= pick;
                  last_buf_reg <= pick;
                  grant_reg[0] <= ~pick;
                  grant_reg[1] <= pick;
                  state_reg    <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               awvalid_reg    <= 1'b1;
               awaddr_reg     <= buf_sel_reg ? BUF1_BASE_g : BUF0_BASE_g;
               loaded_cnt_reg <= '0;
               sent_cnt_reg   <= '0;
               state_reg      <= ST_ADDR;
            end
            ST_ADDR: begin
               if (m_axi_awready_i) begin
                  awvalid_reg <= 1'b0;
                  state_reg   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (src_load) begin
                  wdata_reg      <= src_data_i;
                  wvalid_reg     <= 1'b1;
                  loaded_cnt_reg <= loaded_cnt_reg + ONE_C;
               end else if (w_hs) begin
                  wvalid_reg <= 1'b0;
               end
               if (w_hs) begin
                  sent_cnt_reg <= sent_cnt_reg + ONE_C;
                  if (wlast) begin
                     bready_reg <= 1'b1;
                     state_reg  <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               if (m_axi_bvalid_i) begin
                  bready_reg <= 1'b0;
                  done_reg   <= 1'b1;
                  err_reg    <= |m_axi_bresp_i;
                  state_reg  <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Full-width writes only.
   genvar gi;
   generate
      for (gi = 0; gi < AXI_DW_g/8; gi++) begin : g_strb
         assign m_axi_wstrb_o[gi] = 1'b1;
      end
   endgenerate

   assign busy_o          = (state_reg != ST_IDLE);
   assign done_o          = done_reg;
   assign err_o           = err_reg;
   assign buf_sel_o       = buf_sel_reg;
   assign src_ready_o     = src_ready;
   assign buf_grant_o     = grant_reg;
   assign m_axi_awvalid_o = awvalid_reg;
   assign m_axi_awaddr_o  = awaddr_reg;
   assign m_axi_awlen_o   = 8'(BEATS_g - 1);
   assign m_axi_awsize_o  = 3'd3;
   assign m_axi_awburst_o = 2'b01;
   assign m_axi_wvalid_o  = wvalid_reg;
   assign m_axi_wdata_o   = wdata_reg;
   assign m_axi_wlast_o   = wlast;
   assign m_axi_bready_o  = bready_reg;

endmodule

// File: tb/tb_buffer_dma_mst.sv
// tb_buffer_dma_mst
// Directed bench for buffer_dma_mst: table of tile vectors plus hand-written
// sequences for the SELECT wait and a reset in the middle of a burst.
module tb_buffer_dma_mst;

   localparam int DW    = 64;
   localparam int AW    = 32;
   localparam int BEATS = 16;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic          busy_o, done_o, err_o, buf_sel_o;
   logic          src_valid_i, src_ready_o;
   logic [DW-1:0] src_data_i;
   logic [1:0]    buf_available_i, buf_grant_o;
   logic          m_axi_awvalid_o, m_axi_awready_i;
   logic [AW-1:0] m_axi_awaddr_o;
   logic [7:0]    m_axi_awlen_o;
   logic [2:0]    m_axi_awsize_o;
   logic [1:0]    m_axi_awburst_o;
   logic          m_axi_wvalid_o, m_axi_wready_i;
   logic [DW-1:0] m_axi_wdata_o;
   logic [DW/8-1:0] m_axi_wstrb_o;
   logic          m_axi_wlast_o;
   logic          m_axi_bvalid_i, m_axi_bready_o;
   logic [1:0]    m_axi_bresp_i;

   always #5 clk_i = ~clk_i;

   buffer_dma_mst #(
      .AXI_DW_g(DW), .AXI_AW_g(AW), .BEATS_g(BEATS),
      .BUF0_BASE_g(32'h0000_0000), .BUF1_BASE_g(32'h0000_1000)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .buf_sel_o(buf_sel_o),
      .src_valid_i(src_valid_i), .src_ready_o(src_ready_o), .src_data_i(src_data_i),
      .buf_available_i(buf_available_i), .buf_grant_o(buf_grant_o),
      .m_axi_awvalid_o(m_axi_awvalid_o), .m_axi_awready_i(m_axi_awready_i),
      .m_axi_awaddr_o(m_axi_awaddr_o), .m_axi_awlen_o(m_axi_awlen_o),
      .m_axi_awsize_o(m_axi_awsize_o), .m_axi_awburst_o(m_axi_awburst_o),
      .m_axi_wvalid_o(m_axi_wvalid_o), .m_axi_wready_i(m_axi_wready_i),
      .m_axi_wdata_o(m_axi_wdata_o), .m_axi_wstrb_o(m_axi_wstrb_o),
      .m_axi_wlast_o(m_axi_wlast_o),
      .m_axi_bvalid_i(m_axi_bvalid_i), .m_axi_bready_o(m_axi_bready_o),
      .m_axi_bresp_i(m_axi_bresp_i)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Everything the reset state defines as zero.
   task automatic chk_quiet(input string tag);
      chk({tag, " busy"},     busy_o, 0);
      chk({tag, " done"},     done_o, 0);
      chk({tag, " err"},      err_o, 0);
      chk({tag, " buf_sel"},  buf_sel_o, 0);
      chk({tag, " src_rdy"},  src_ready_o, 0);
      chk({tag, " grant"},    buf_grant_o, 0);
      chk({tag, " awvalid"},  m_axi_awvalid_o, 0);
      chk({tag, " awaddr"},   m_axi_awaddr_o, 0);
      chk({tag, " wvalid"},   m_axi_wvalid_o, 0);
      chk({tag, " wlast"},    m_axi_wlast_o, 0);
      chk({tag, " wdata"},    m_axi_wdata_o, 0);
      chk({tag, " bready"},   m_axi_bready_o, 0);
   endtask

   // Runs one tile from the slave/source side. Inputs change on the falling
   // edge; outputs are sampled 1 time unit later, which also tells which
   // handshakes the next rising edge will complete.
   task automatic run_tile(input string tag, input bit do_start, input logic [1:0] avail,
                           input bit throttle, input logic [1:0] bresp, input int n_grant,
                           input logic [1:0] exp_grant, input logic [31:0] exp_addr,
                           input logic exp_err, input int exp_lat, input int abort_at,
                           input logic [63:0] base);
      int          n = 0, beats = 0, src_idx = 0, grants = 0, aws = 0;
      bit          aw_done = 0, b_pend = 0, stall = 0, fin = 0;
      logic [63:0] held = '0;
      logic [31:0] addr_seen = '0;
      buf_available_i = avail;
      if (do_start) begin
         @(negedge clk_i);
         start_i = 1'b1;
      end
      while (!fin && n < 400) begin
         @(negedge clk_i);
         n++;
         start_i         = 1'b0;
         src_valid_i     = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
         src_data_i      = src_valid_i ? base + 64'(src_idx) : 64'hDEAD_BEEF_0BAD_F00D;
         m_axi_wready_i  = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
         m_axi_awready_i = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
         m_axi_bvalid_i  = b_pend;
         m_axi_bresp_i   = b_pend ? bresp : 2'b00;
         #1;
         if (buf_grant_o != 2'b00) begin
            grants++;
            chk({tag, " grant"}, buf_grant_o, exp_grant);
         end
         if (stall) begin
            chk({tag, " wvalid held"}, m_axi_wvalid_o, 1);
            chk({tag, " wdata held"}, m_axi_wdata_o, held);
         end
         stall = 0;
         if (!aw_done) chk({tag, " w before aw"}, m_axi_wvalid_o, 0);
         if (m_axi_awvalid_o && m_axi_awready_i) begin
            aws++;
            aw_done   = 1;
            addr_seen = m_axi_awaddr_o;
            chk({tag, " awlen"}, m_axi_awlen_o, BEATS - 1);
            chk({tag, " awsize"}, m_axi_awsize_o, 3);
            chk({tag, " awburst"}, m_axi_awburst_o, 1);
         end
         if (m_axi_wvalid_o) begin
            if (m_axi_wready_i) begin
               chk({tag, " wdata"}, m_axi_wdata_o, base + 64'(beats));
               chk({tag, " wlast"}, m_axi_wlast_o, (beats == BEATS - 1));
               chk({tag, " wstrb"}, m_axi_wstrb_o, 8'hFF);
               beats++;
               if (m_axi_wlast_o) b_pend = 1;
            end else begin
               stall = 1;
               held  = m_axi_wdata_o;
            end
         end
         if (src_idx >= BEATS) chk({tag, " src_ready after last"}, src_ready_o, 0);
         if (src_valid_i && src_ready_o) src_idx++;
         if (m_axi_bvalid_i && m_axi_bready_o) b_pend = 0;
         if (abort_at > 0 && beats == abort_at) begin
            fin = 1;
            #2;
            rst_i = 1'b1;
            #1;
            chk_quiet({tag, " async rst"});
            @(negedge clk_i);
            rst_i = 1'b0;
            $display("tile %s aborted by reset after %0d beats", tag, beats);
         end else if (done_o) begin
            fin = 1;
            chk({tag, " err"}, err_o, exp_err);
            chk({tag, " beats"}, beats, BEATS);
            chk({tag, " src words"}, src_idx, BEATS);
            chk({tag, " grant count"}, grants, n_grant);
            chk({tag, " aw count"}, aws, 1);
            chk({tag, " awaddr"}, addr_seen, exp_addr);
            chk({tag, " busy at done"}, busy_o, 0);
            if (exp_lat > 0) chk({tag, " latency"}, n - 1, exp_lat);
            $display("tile %s grant=%b awaddr=0x%0h beats=%0d err=%b cycles=%0d",
                     tag, exp_grant, addr_seen, beats, err_o, n - 1);
            @(negedge clk_i);
            #1;
            chk({tag, " done pulse"}, done_o, 0);
            chk({tag, " err pulse"}, err_o, 0);
         end
      end
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: no done_o after %0d cycles", tag, n);
      end
   endtask

   typedef struct {
      logic [1:0]  avail;
      bit          throttle;
      logic [1:0]  bresp;
      logic [1:0]  exp_grant;
      logic [31:0] exp_addr;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs[4];

   initial begin
      vecs[0] = '{2'b11, 1'b0, 2'b00, 2'b01, 32'h0000_0000, 1'b0, BEATS + 5};
      vecs[1] = '{2'b11, 1'b0, 2'b00, 2'b10, 32'h0000_1000, 1'b0, BEATS + 5};
      vecs[2] = '{2'b11, 1'b1, 2'b00, 2'b01, 32'h0000_0000, 1'b0, 0};
      vecs[3] = '{2'b11, 1'b0, 2'b10, 2'b10, 32'h0000_1000, 1'b1, BEATS + 5};

      rst_i           = 1'b1;
      start_i         = 1'b0;
      src_valid_i     = 1'b0;
      src_data_i      = '0;
      buf_available_i = 2'b00;
      m_axi_awready_i = 1'b0;
      m_axi_wready_i  = 1'b0;
      m_axi_bvalid_i  = 1'b0;
      m_axi_bresp_i   = 2'b00;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      chk_quiet("reset");

      for (int i = 0; i < 4; i++) begin
         run_tile($sformatf("vec%0d", i), 1'b1, vecs[i].avail, vecs[i].throttle,
                  vecs[i].bresp, 1, vecs[i].exp_grant, vecs[i].exp_addr,
                  vecs[i].exp_err, vecs[i].exp_lat, 0, 64'(i) * 64'h100);
      end

      // Block must sit in SELECT with no buffer free, then grant buffer 0 one
      // cycle after it becomes available.
      buf_available_i = 2'b00;
      @(negedge clk_i);
      start_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         start_i = 1'b0;
         #1;
         chk("selwait busy", busy_o, 1);
         chk("selwait grant", buf_grant_o, 2'b00);
      end
      @(negedge clk_i);
      buf_available_i = 2'b01;
      #1;
      chk("selwait grant before edge", buf_grant_o, 2'b00);
      @(negedge clk_i);
      #1;
      chk("selwait grant after avail", buf_grant_o, 2'b01);
      chk("selwait buf_sel", buf_sel_o, 0);
      run_tile("selwait", 1'b0, 2'b01, 1'b0, 2'b00, 0, 2'b01, 32'h0000_0000,
               1'b0, 0, 0, 64'h400);

      // Buffer 1 is due next; reset mid-burst must restart from buffer 0.
      run_tile("abort", 1'b1, 2'b11, 1'b0, 2'b00, 1, 2'b10, 32'h0000_1000,
               1'b0, 0, 8, 64'h500);
      run_tile("post_reset", 1'b1, 2'b11, 1'b0, 2'b00, 1, 2'b01, 32'h0000_0000,
               1'b0, BEATS + 5, 0, 64'h600);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/buffer_dma_mst.md
# buffer_dma_mst

AXI4 write-master that moves one tile of `BEATS_g` 64-bit words from a streaming source into one of two blocking input buffers of the systolic array. It arbitrates between the buffers using their `available` status and issues the single-cycle grant that moves the chosen buffer into its loading phase. It then performs one INCR burst (AW, W, B) into it. It sits between the tile producer (DMA read side / scratchpad) and the double-buffered systolic-array front end.

## Interface
Parameters:
- `AXI_DW_g`, 64: data width; `AXI_DW_g/8` strobe bits.
- `AXI_AW_g`, 32: address width.
- `BEATS_g`, 16: beats per tile (2..256).
- `BUF0_BASE_g`, 32'h0000_0000: AW address for buffer 0.
- `BUF1_BASE_g`, 32'h0000_1000: AW address for buffer 1.

Ports:
- `clk_i` in 1: clock; all logic is on the rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: request one tile transfer; sampled only in IDLE.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse when the B handshake completes.
- `err_o` out 1: valid with `done_o`; high if `bresp != 2'b00`.
- `buf_sel_o` out 1: index of the buffer currently being filled; held until the next selection.
- `src_valid_i` in 1: source word valid.
- `src_ready_o` out 1: source word accepted.
- `src_data_i` in AXI_DW_g: source word.
- `buf_available_i` in 2: per-buffer available status.
- `buf_grant_o` out 2: one-hot, single-cycle grant pulse.
- `m_axi_awvalid_o` out 1 / `m_axi_awready_i` in 1: AW handshake.
- `m_axi_awaddr_o` out AXI_AW_g: base address of the selected buffer.
- `m_axi_awlen_o` out 8: constant `BEATS_g-1`.
- `m_axi_awsize_o` out 3: constant 3'd3 (8 bytes per beat).
- `m_axi_awburst_o` out 2: constant 2'b01 (INCR).
- `m_axi_wvalid_o` out 1 / `m_axi_wready_i` in 1: W handshake.
- `m_axi_wdata_o` out AXI_DW_g: write data.
- `m_axi_wstrb_o` out AXI_DW_g/8: all ones.
- `m_axi_wlast_o` out 1: last beat of the burst.
- `m_axi_bvalid_i` in 1 / `m_axi_bready_o` out 1: B handshake.
- `m_axi_bresp_i` in 2: write response.

## Operation
- States: IDLE, SELECT, GRANT, ADDR, DATA, RESP.
- IDLE:
  - `start_i` moves to SELECT.
- SELECT:
  - Waits until at least one `buf_available_i` bit is high.
  - If both are high, picks `~last_buf`; otherwise picks the single available one.
  - Registers the choice into `buf_sel_o` and `last_buf`, then moves to GRANT.
- GRANT:
  - Asserts `buf_grant_o[buf_sel_o]` for exactly one cycle, then moves to ADDR.
- ADDR:
  - `awvalid` is high with a stable `awaddr`.
  - On `awvalid && awready`, moves to DATA.
- DATA:
  - Uses a single output data register, loaded when `src_valid_i && src_ready_o`.
  - `src_ready_o = (state==DATA) && (!wvalid || wready) && (loaded_cnt < BEATS_g)`.
  - `wvalid` stays high while the register holds an unsent word; `wdata` is stable while `wvalid && !wready`.
  - `sent_cnt` counts W handshakes; `wlast = wvalid && (sent_cnt == BEATS_g-1)`.
  - The handshake with `wlast` high moves to RESP.
- RESP:
  - `bready` is high.
  - On `bvalid`, pulses `done_o`, sets `err_o = |bresp`, and returns to IDLE.
- Counters are `$clog2(BEATS_g)+1` bits wide, cleared on entering ADDR, and never wrap.
- Exactly `BEATS_g` source words are consumed per tile; further source words are stalled by `src_ready_o`.
- `start_i` is ignored while busy and is not queued.
- A buffer whose available bit drops after its grant still receives the burst; that is the slave's concern.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State is IDLE; `last_buf` is 1, so buffer 0 is served first.
  - `buf_sel_o` is 0.
  - All valid, ready, grant, `done_o` and `err_o` outputs are 0.
  - `awaddr` and `wdata` are 0.
- Reset in any state aborts the burst immediately; no partial AXI transaction is completed.
- Minimum cycles from `start_i` to `done_o`, with all ready/valid inputs continuously high and both buffers available:
  - 1 cycle: SELECT.
  - 1 cycle: GRANT.
  - 1 cycle: AW.
  - `BEATS_g+1` cycles: data register fill plus streaming.
  - 1 cycle: B.
- `awvalid` rises the cycle after the grant pulse; the slave is in its loading state by then.
- W never precedes the AW handshake.
- With `src_valid_i` and `wready` both high, W sustains one beat per cycle (no bubbles).
- `done_o` and `err_o` are registered: they assert the cycle after the B handshake.

## Test plan
- Reset, then `start_i`, both buffers available, source words 0..15 streaming, all readies high:
  - grant `2'b01`;
  - `awaddr=0x0`, `awlen=15`, `awburst=1`;
  - 16 W beats carrying 0..15 with `wlast` on the 16th;
  - `done_o` high, `err_o` low.
- Two consecutive tiles with both buffers available:
  - grants `2'b01` then `2'b10`;
  - `awaddr` 0x0 then 0x1000.
- Only buffer 0 available on the second tile:
  - block stays in SELECT while `buf_available_i=2'b00`;
  - grant `2'b01` is issued 1 cycle after `buf_available_i` becomes `2'b01`.
- Random `wready` / `src_valid_i` throttling (50%):
  - `wdata` is held stable under stall;
  - exactly 16 beats and the data order is preserved;
  - `src_ready_o` is low after the 16th accept.
- `bresp=2'b10`:
  - `done_o` and `err_o` both assert for one cycle;
  - the next `start_i` proceeds normally.
- Assert `rst_i` mid-DATA (after beat 7):
  - all outputs go to 0 asynchronously;
  - the next tile starts with buffer 0 and `awaddr=0x0`.
